// File: rtl/bram_result_reader.sv
// bram_result_reader: reads packed result words from BRAM1, splits each word
// into LANE_WIDTH-bit lanes (most-significant lane first) and streams them out
// on a valid/ready interface. Control mirrors the accessor's
// start/run_count/idle/read/done handshake.
module bram_result_reader #(
    parameter int CNT_BIT    = 31,
    parameter int DWIDTH     = 64,
    parameter int AWIDTH     = 8,
    parameter int LANE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_run_i,
    input  logic [CNT_BIT-1:0]    run_count_i,
    output logic                  idle_o,
    output logic                  read_o,
    output logic                  done_o,
    output logic [AWIDTH-1:0]     addr_b1_o,
    output logic                  ce_b1_o,
    output logic                  we_b1_o,
    input  logic [DWIDTH-1:0]     q_b1_i,
    output logic [LANE_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o
);

    localparam int LANES  = DWIDTH / LANE_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        EMIT,
        DONE
    } state_t;

    state_t              state;
    logic [CNT_BIT-1:0]  count;
    logic [CNT_BIT-1:0]  word_cnt;
    logic [LANE_W-1:0]   lane;
    logic [DWIDTH-1:0]   word_reg;
    logic [DWIDTH-1:0]   word_shifted;
    logic [CNT_BIT:0]    word_cnt_next;
    logic                lane_accept;

    // One extra bit so word_cnt+1 cannot overflow before the compare.
    assign word_cnt_next = {1'b0, word_cnt} + (CNT_BIT + 1)'(1);
    assign lane_accept   = (state == EMIT) && m_ready_i;

    // Sequencer: start latch, BRAM read, word capture, lane emission, done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            word_cnt <= '0;
            lane     <= '0;
            word_reg <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so the order of statements below is irrelevant.
            case (state)
                IDLE: begin
                    if (start_run_i) begin
                        if (run_count_i == '0) begin
                            state <= DONE;
                        end else begin
                            count    <= run_count_i;
                            word_cnt <= '0;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    state <= LATCH;
                end
                LATCH: begin
                    word_reg <= q_b1_i;
                    lane     <= '0;
                    state    <= EMIT;
                end
                EMIT: begin
                    if (lane_accept) begin
                        if (lane == LAST_LANE) begin
                            word_cnt <= word_cnt_next[CNT_BIT-1:0];
                            state    <= (word_cnt_next < {1'b0, count}) ? READ : DONE;
                        end else begin
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Lane select: shift the chosen lane into the top bits of the word.
    assign word_shifted = word_reg << (int'(lane) * LANE_WIDTH);

    // Outputs are pure decodes of registered state, so m_ready_i never
    // reaches an output combinationally and reset clears them at once.
    assign idle_o    = (state == IDLE);
    assign read_o    = (state == READ) || (state == LATCH) || (state == EMIT);
    assign done_o    = (state == DONE);
    assign ce_b1_o   = (state == READ);
    assign we_b1_o   = 1'b0;
    assign addr_b1_o = (state == READ) ? word_cnt[AWIDTH-1:0] : '0;
    assign m_valid_o = (state == EMIT);
    assign m_data_o  = (state == EMIT) ? word_shifted[DWIDTH-1 -: LANE_WIDTH] : '0;
    assign m_last_o  = (state == EMIT) && (lane == LAST_LANE)
                       && (word_cnt == count - CNT_BIT'(1));

endmodule

// File: doc/bram_result_reader.md
Name: bram_result_reader

Overview:
- Reads packed result words back out of BRAM1, the 64-bit result memory filled by the accessor's write path.
- Unpacks each word into LANE_WIDTH-bit lanes, most-significant lane first.
- Presents the lanes on a valid/ready output stream for the host or DMA side.
- Uses the same start/run_count/idle/read/done control style as the accessor, so one register block can sequence both.

Parameters:
- CNT_BIT, 31: width of run_count_i and of the internal word counter.
- DWIDTH, 64: BRAM1 data width. Must be an integer multiple of LANE_WIDTH.
- AWIDTH, 8: BRAM1 address width.
- LANE_WIDTH, 16: width of one unpacked result. LANES = DWIDTH/LANE_WIDTH, which is 4 by default.

Ports:
- clk  in  1  clock, all flops on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_run_i  in  1  start pulse. Sampled only in IDLE.
- run_count_i  in  CNT_BIT  number of BRAM1 words to read. Latched on start.
- idle_o  out  1  FSM is in IDLE.
- read_o  out  1  FSM is in READ, LATCH or EMIT.
- done_o  out  1  one-cycle pulse in the DONE state.
- addr_b1_o  out  AWIDTH  BRAM1 address.
- ce_b1_o  out  1  BRAM1 chip enable.
- we_b1_o  out  1  BRAM1 write enable, tied to 0.
- q_b1_i  in  DWIDTH  BRAM1 read data. Valid one cycle after ce_b1_o.
- m_data_o  out  LANE_WIDTH  current lane.
- m_valid_o  out  1  lane valid.
- m_ready_i  in  1  downstream accepts the lane.
- m_last_o  out  1  final lane of the final word.

Behaviour:
- Reset:
  - FSM goes to IDLE; word counter, lane counter and word register clear to 0.
  - idle_o=1. All other outputs are 0, including addr_b1_o and m_data_o.
  - Reset asserted mid-operation aborts immediately; m_valid_o drops asynchronously. No done_o is produced for the aborted run.
- FSM has five states: IDLE, READ, LATCH, EMIT, DONE.
- IDLE:
  - start_run_i=1 with run_count_i=0 goes to DONE.
  - start_run_i=1 with run_count_i>0 latches the count, clears the word counter and goes to READ.
  - start_run_i is ignored in every other state.
- READ, one cycle:
  - ce_b1_o=1, we_b1_o=0, addr_b1_o = word_cnt[AWIDTH-1:0].
  - Addresses wrap modulo 2^AWIDTH when the count exceeds memory depth.
  - Next state is LATCH.
- LATCH, one cycle:
  - ce_b1_o=0; the word register captures q_b1_i.
  - Lane counter cleared; next state is EMIT.
- EMIT:
  - m_valid_o=1.
  - m_data_o = word_reg[DWIDTH-1-lane*LANE_WIDTH -: LANE_WIDTH], so lane 0 is bits [63:48].
  - The lane advances only when m_valid_o and m_ready_i are both 1. While m_ready_i=0, m_data_o and m_last_o hold stable.
  - When the last lane (LANES-1) is accepted, word_cnt increments.
  - Next state is READ if word_cnt+1 < count, otherwise DONE.
- m_last_o=1 only on lane LANES-1 when word_cnt = count-1.
- DONE: done_o=1 for one cycle, then return to IDLE.
- Latency:
  - start sampled at edge T.
  - ce_b1_o high in cycle T+1.
  - First m_valid_o in cycle T+3.
  - Each word costs 2 + LANES cycles minimum, i.e. 6 cycles at default parameters with m_ready_i held high.
- All outputs are decoded from registered state, counters and word register. There is no combinational path from m_ready_i to any output.

Test Plan:
- Reset values: hold reset for 3 cycles, then release. Required: idle_o=1; read_o, done_o, ce_b1_o, we_b1_o and m_valid_o all 0; addr_b1_o=0.
- Single word, no backpressure:
  - Stimulus: bram1[0]=0x0001_0003_0005_0007, run_count=1, m_ready_i=1.
  - Required: ce_b1_o high exactly once with addr 0; m_data_o = 0x0001, 0x0003, 0x0005, 0x0007 on consecutive cycles from T+3.
  - Required: m_last_o only with 0x0007; done_o pulses the following cycle, then idle_o=1.
- Zero count: run_count=0 with start. Required: done_o in cycle T+1; no ce_b1_o, no m_valid_o.
- Backpressure:
  - Stimulus: bram1[k]={16'(4k),16'(4k+1),16'(4k+2),16'(4k+3)}, run_count=3, m_ready_i toggling in a pseudo-random pattern.
  - Required: exactly 12 accepted beats in order 0..11; data stable while stalled; m_last_o only on beat 11; addresses 0,1,2.
- Wrap:
  - Stimulus: run_count=257 with AWIDTH=8.
  - Required: the 257th read uses addr 0; 1028 beats total; one done_o pulse.
- Start while busy, then reset mid-EMIT:
  - start_run_i pulsed while in EMIT is ignored: beat count unchanged.
  - reset asserted mid-EMIT: m_valid_o drops immediately, no done_o, idle_o=1.
  - A fresh start after reset runs normally from addr 0.
